controle_bomba: RTL and testbench

Game controller for the bomb-clock design, directly downstream of the password comparator. Consumes the comparator's `ACERTOU_SENHA_A`/`ACERTOU_SENHA_B` flags and the same `ENTER` strobe, and drives the comparator's `ENABLE`. Owns the arm/disarm state machine, the seconds countdown, the wrong-attempt counter and the final DESARMADA/EXPLODIU outcome.

---
 rtl/bomba_pkg.sv | 20 ++
 rtl/sincroniza_borda.sv | 27 ++
 rtl/controle_bomba.sv | 123 ++++++++++++
 tb/tb_controle_bomba.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bomba_pkg.sv
// Shared types and widths for the bomb-clock game controller.
package bomba_pkg;

    localparam int TEMPO_W = 7;
    localparam int ERROS_W = 3;

    typedef enum logic [2:0] {
        E_OCIOSA    = 3'd0,
        E_ARMADA_A  = 3'd1,
        E_ARMADA_B  = 3'd2,
        E_DESARMADA = 3'd3,
        E_EXPLODIDA = 3'd4
    } estado_t;

    // Seconds remaining after removing b, clamped at zero.
    function automatic logic [TEMPO_W-1:0] sub_sat(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? TEMPO_W'(a - b) : '0;
    endfunction

endpackage

// File: rtl/sincroniza_borda.sv
// Two-flop synchronizer for an asynchronous button level plus a one-cycle rising-edge pulse.
module sincroniza_borda (
    input  logic CLK,
    input  logic RESET,
    input  logic i_d,
    output logic o_pulso
);

    logic r_meta;
    logic r_sync;
    logic r_ant;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_ant  <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_ant  <= r_sync;
        end
    end

    assign o_pulso = r_sync & ~r_ant;

endmodule

// File: rtl/controle_bomba.sv
// Bomb-clock game controller: arm/disarm FSM, seconds countdown, wrong-attempt counter.
module controle_bomba
    import bomba_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int TEMPO_INICIAL = 60,
    parameter int MAX_ERROS     = 3,
    parameter int PENALIDADE    = 5
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               START,
    input  logic               ENTER,
    input  logic               ACERTOU_SENHA_A,
    input  logic               ACERTOU_SENHA_B,
    output logic               ENABLE,
    output logic [TEMPO_W-1:0] TEMPO,
    output logic [ERROS_W-1:0] ERROS,
    output logic               FASE_B,
    output logic               DESARMADA,
    output logic               EXPLODIU
);

    localparam int                 PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]      PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [TEMPO_W-1:0] TEMPO_RST = TEMPO_W'(TEMPO_INICIAL);
    localparam logic [ERROS_W-1:0] ERROS_LIM = ERROS_W'(MAX_ERROS);

    estado_t            r_estado;
    estado_t            w_prox;
    logic [TEMPO_W-1:0] r_tempo;
    logic [TEMPO_W-1:0] w_tempo_novo;
    logic [ERROS_W-1:0] r_erros;
    logic [ERROS_W-1:0] w_erros_novo;
    logic [PW-1:0]      r_presc;
    logic [31:0]        w_desconto;
    logic               r_avaliar;
    logic               w_start_p;
    logic               w_enter_p;
    logic               w_armada;
    logic               w_tick;
    logic               w_acerto;
    logic               w_erro;

    sincroniza_borda u_sync_start (
        .CLK    (CLK),
        .RESET  (RESET),
        .i_d    (START),
        .o_pulso(w_start_p)
    );

    sincroniza_borda u_sync_enter (
        .CLK    (CLK),
        .RESET  (RESET),
        .i_d    (ENTER),
        .o_pulso(w_enter_p)
    );

    always_comb begin
        w_armada     = (r_estado == E_ARMADA_A) || (r_estado == E_ARMADA_B);
        w_tick       = w_armada && (r_presc == PRESC_MAX);
        w_acerto     = r_avaliar && (((r_estado == E_ARMADA_A) && ACERTOU_SENHA_A) ||
                                     ((r_estado == E_ARMADA_B) && ACERTOU_SENHA_B));
        w_erro       = r_avaliar && w_armada && !w_acerto;
        // Penalty and the per-second tick combine into one saturating subtraction.
        w_desconto   = (w_erro ? 32'(PENALIDADE) : 32'd0) + (w_tick ? 32'd1 : 32'd0);
        w_tempo_novo = sub_sat(32'(r_tempo), w_desconto);
        w_erros_novo = r_erros + ERROS_W'(w_erro);
    end

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            E_OCIOSA: begin
                if (w_start_p) w_prox = E_ARMADA_A;
            end
            E_ARMADA_A, E_ARMADA_B: begin
                // A countdown that reached zero on the previous edge explodes now.
                if (r_tempo == '0)
                    w_prox = E_EXPLODIDA;
                else if (w_acerto)
                    w_prox = (r_estado == E_ARMADA_A) ? E_ARMADA_B : E_DESARMADA;
                else if (w_erro && ((w_erros_novo == ERROS_LIM) || (w_tempo_novo == '0)))
                    w_prox = E_EXPLODIDA;
            end
            default: w_prox = r_estado;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_estado  <= E_OCIOSA;
            r_tempo   <= TEMPO_RST;
            r_erros   <= '0;
            r_presc   <= '0;
            r_avaliar <= 1'b0;
            ENABLE    <= 1'b0;
            FASE_B    <= 1'b0;
            DESARMADA <= 1'b0;
            EXPLODIU  <= 1'b0;
        end else begin
            r_avaliar <= w_enter_p;
            r_estado  <= w_prox;
            ENABLE    <= (w_prox == E_ARMADA_A) || (w_prox == E_ARMADA_B);
            FASE_B    <= (w_prox == E_ARMADA_B);
            DESARMADA <= (w_prox == E_DESARMADA);
            EXPLODIU  <= (w_prox == E_EXPLODIDA);
            if ((r_estado == E_OCIOSA) && w_start_p) begin
                r_tempo <= TEMPO_RST;
                r_erros <= '0;
                r_presc <= '0;
            end else if (w_armada) begin
                r_tempo <= w_tempo_novo;
                r_erros <= w_erros_novo;
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            end
        end
    end

    assign TEMPO = r_tempo;
    assign ERROS = r_erros;

endmodule

// File: tb/tb_controle_bomba.sv
// Self-checking bench for controle_bomba: directed game scenarios plus random play against a reference model.
module tb_controle_bomba;

    localparam int CLK_HZ = 4;
    localparam int T0     = 10;
    localparam int MAXE   = 3;
    localparam int PEN    = 2;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START;
    logic       ENTER;
    logic       FA;
    logic       FB;
    logic       ENABLE;
    logic [6:0] TEMPO;
    logic [2:0] ERROS;
    logic       FASE_B;
    logic       DESARMADA;
    logic       EXPLODIU;

    always #5 CLK = ~CLK;

    controle_bomba #(
        .CLK_HZ       (CLK_HZ),
        .TEMPO_INICIAL(T0),
        .MAX_ERROS    (MAXE),
        .PENALIDADE   (PEN)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .START          (START),
        .ENTER          (ENTER),
        .ACERTOU_SENHA_A(FA),
        .ACERTOU_SENHA_B(FB),
        .ENABLE         (ENABLE),
        .TEMPO          (TEMPO),
        .ERROS          (ERROS),
        .FASE_B         (FASE_B),
        .DESARMADA      (DESARMADA),
        .EXPLODIU       (EXPLODIU)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference game: 0 idle, 1 phase A, 2 phase B, 3 disarmed, 4 exploded.
    int m_est;
    int m_tempo;
    int m_erros;
    int m_cyc;
    logic [2:0] s_h;
    logic [3:0] e_h;

    localparam logic [13:0] VEC_RESET = {4'b0000, 3'd0, 7'd10};

    function automatic logic [13:0] observado();
        return {ENABLE, FASE_B, DESARMADA, EXPLODIU, ERROS, TEMPO};
    endfunction

    function automatic logic [13:0] esperado();
        return {(m_est == 1) || (m_est == 2), m_est == 2, m_est == 3, m_est == 4,
                3'(m_erros), 7'(m_tempo)};
    endfunction

    task automatic verifica(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_est   = 0;
        m_tempo = T0;
        m_erros = 0;
        m_cyc   = 0;
        s_h     = '0;
        e_h     = '0;
    endtask

    // Button levels are sampled per edge; a press is seen 2 edges (START) or 3 edges (ENTER) after it is first sampled.
    task automatic model_borda(input logic sv, input logic ev, input logic fa, input logic fb);
        logic start_ev, aval, ok, bad, tick;
        int t, nxt;
        start_ev = s_h[1] & ~s_h[2];
        aval     = e_h[2] & ~e_h[3];
        s_h      = {s_h[1:0], sv};
        e_h      = {e_h[2:0], ev};
        if (m_est == 0) begin
            if (start_ev) begin
                m_est = 1; m_tempo = T0; m_erros = 0; m_cyc = 0;
            end
        end else if ((m_est == 1) || (m_est == 2)) begin
            tick = ((m_cyc % CLK_HZ) == (CLK_HZ - 1));
            m_cyc++;
            ok  = aval && ((m_est == 1) ? fa : fb);
            bad = aval && !ok;
            t = m_tempo - (bad ? PEN : 0) - (tick ? 1 : 0);
            if (t < 0) t = 0;
            if (m_tempo == 0)                                   nxt = 4;
            else if (ok)                                        nxt = (m_est == 1) ? 2 : 3;
            else if (bad && ((m_erros + 1 == MAXE) || (t == 0))) nxt = 4;
            else                                                nxt = m_est;
            m_tempo = t;
            m_erros = m_erros + int'(bad);
            m_est   = nxt;
        end
    endtask

    task automatic passo(input string tag);
        logic sv, ev, fa, fb;
        sv = START; ev = ENTER; fa = FA; fb = FB;
        @(posedge CLK);
        if (RESET) model_reset();
        else       model_borda(sv, ev, fa, fb);
        @(negedge CLK);
        verifica(tag, observado(), esperado());
    endtask

    task automatic aplica_reset();
        START = 1'b0; ENTER = 1'b0; FA = 1'b0; FB = 1'b0;
        RESET = 1'b1;
        #1;
        model_reset();
        verifica("reset_async", observado(), VEC_RESET);
        passo("reset_hold");
        RESET = 1'b0;
    endtask

    task automatic pulsa_start();
        START = 1'b1;
        repeat (2) passo("start");
        START = 1'b0;
        passo("start");
    endtask

    task automatic pressiona(input logic fa, input logic fb);
        FA = fa; FB = fb;
        ENTER = 1'b1;
        repeat (2) passo("enter");
        ENTER = 1'b0;
        repeat (2) passo("enter");
    endtask

    // Advance until the next ENTER press would be evaluated on a tick edge with TEMPO at alvo.
    task automatic espera(input int alvo);
        logic achou;
        achou = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (((m_est == 1) || (m_est == 2)) && (m_tempo == alvo) && ((m_cyc % CLK_HZ) == 0)) begin
                achou = 1'b1;
                break;
            end
            passo("espera");
        end
        verifica("espera_alvo", {13'b0, achou}, 14'd1);
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; ENTER = 1'b0; FA = 1'b0; FB = 1'b0;
        model_reset();
        @(negedge CLK);
        verifica("reset_state", observado(), VEC_RESET);
        RESET = 1'b0;

        // Arm and count down
        pulsa_start();
        verifica("arm", observado(), {4'b1000, 3'd0, 7'd10});
        repeat (16) passo("count");
        verifica("tempo_after_16", observado(), {4'b1000, 3'd0, 7'd6});

        // Full disarm
        pressiona(1'b1, 1'b0);
        verifica("fase_b", {13'b0, FASE_B}, 14'd1);
        pressiona(1'b1, 1'b1);
        verifica("desarmada", {12'b0, ENABLE, DESARMADA}, 14'd1);
        repeat (8) passo("frozen_des");

        // Three wrong attempts
        aplica_reset();
        pulsa_start();
        pressiona(1'b0, 1'b0);
        verifica("erros_1", {11'b0, ERROS}, 14'd1);
        pressiona(1'b0, 1'b0);
        verifica("erros_2", {11'b0, ERROS}, 14'd2);
        pressiona(1'b0, 1'b0);
        verifica("explode_erros", {10'b0, EXPLODIU, ERROS}, {10'b0, 1'b1, 3'd3});
        repeat (8) passo("frozen_exp");

        // Timeout, then START ignored
        aplica_reset();
        pulsa_start();
        repeat (45) passo("timeout");
        verifica("timeout", {6'b0, EXPLODIU, TEMPO}, {6'b0, 1'b1, 7'd0});
        pulsa_start();
        repeat (3) passo("start_ignored");
        verifica("start_ignored", {12'b0, ENABLE, EXPLODIU}, 14'd1);

        // Error on the same edge as a tick at TEMPO=2
        aplica_reset();
        pulsa_start();
        espera(2);
        pressiona(1'b0, 1'b0);
        verifica("erro_tick", {3'b0, EXPLODIU, ERROS, TEMPO}, {3'b0, 1'b1, 3'd1, 7'd0});

        // B success on the final tick
        aplica_reset();
        pulsa_start();
        pressiona(1'b1, 1'b0);
        espera(1);
        pressiona(1'b1, 1'b1);
        verifica("b_tick", {5'b0, DESARMADA, EXPLODIU, TEMPO}, {5'b0, 1'b1, 1'b0, 7'd0});

        // Asynchronous reset in phase B, then re-arm
        aplica_reset();
        pulsa_start();
        pressiona(1'b1, 1'b0);
        repeat (3) passo("fase_b_run");
        #2;
        RESET = 1'b1;
        #1;
        model_reset();
        verifica("reset_mid", observado(), VEC_RESET);
        passo("reset_mid_hold");
        RESET = 1'b0; FA = 1'b0; FB = 1'b0;
        pulsa_start();
        verifica("rearm", {3'b0, ENABLE, ERROS, TEMPO}, {3'b0, 1'b1, 3'd0, 7'd10});

        // Random play
        repeat (8) begin
            aplica_reset();
            pulsa_start();
            for (int a = 0; (a < 40) && ((m_est == 1) || (m_est == 2)); a++) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r < 7) begin
                    FA = 1'($urandom_range(0, 1));
                    FB = 1'($urandom_range(0, 1));
                    ENTER = 1'b1;
                    repeat ($urandom_range(1, 6)) passo("rnd_press");
                    ENTER = 1'b0;
                    repeat ($urandom_range(1, 4)) passo("rnd_gap");
                end else if (r == 7) begin
                    pulsa_start();
                end else begin
                    repeat ($urandom_range(1, 6)) passo("rnd_idle");
                end
            end
            repeat (6) passo("rnd_end");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
